dmem_write_buffer: RTL

Four-lane data-memory front end that sits directly downstream of the four-issue core's M-stage memory ports. It accepts up to four stores per cycle into an in-order write queue and drains one queued store per cycle into an internal single-write-port data RAM. It answers four combinational loads per cycle, forwarding from same-cycle older stores and from the queue so program order is preserved. When the queue lacks space it asserts a stall to the hazard unit.

---
 rtl/dmem_write_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_write_buffer.sv
// Four-lane data-memory front end: in-order store queue draining one store per cycle into a word RAM,
// with zero-cycle load forwarding. Optional DMEM_WBUF_BYPASS_EN writes a lone store to an empty queue straight to RAM.
module dmem_write_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned RAM_AW = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwriteM,
    input  logic                     memwriteM2,
    input  logic                     memwriteM3,
    input  logic                     memwriteM4,
    input  logic [31:0]              dataadrM,
    input  logic [31:0]              dataadrM2,
    input  logic [31:0]              dataadrM3,
    input  logic [31:0]              dataadrM4,
    input  logic [31:0]              writedata2M,
    input  logic [31:0]              writedata2M2,
    input  logic [31:0]              writedata2M3,
    input  logic [31:0]              writedata2M4,
    output logic [31:0]              readdataM,
    output logic [31:0]              readdataM2,
    output logic [31:0]              readdataM3,
    output logic [31:0]              readdataM4,
    output logic                     bufstallM,
    output logic [$clog2(DEPTH):0]   wbuf_count,
    output logic                     wbuf_empty
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned TW    = 30;
    localparam int unsigned LANES = 4;
    localparam int unsigned WORDS = 2 ** RAM_AW;

    logic [LANES-1:0] w_we;
    logic [TW-1:0]    w_tag  [LANES];
    logic [31:0]      w_wd   [LANES];
    logic [31:0]      w_rd   [LANES];
    logic [PW-1:0]    w_slot [LANES];
    logic [2:0]       w_n;
    logic [CW-1:0]    w_space;
    logic [CW-1:0]    w_add;
    logic             w_acc;
    logic             w_enq;
    logic             w_drain;
    logic             w_byp;
    logic             w_unused_adr;

    logic [TW-1:0]    r_q_tag  [DEPTH];
    logic [31:0]      r_q_data [DEPTH];
    logic [31:0]      r_ram    [WORDS];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    // Store valids are masked during reset so nothing is admitted or forwarded.
    assign w_we     = {memwriteM4, memwriteM3, memwriteM2, memwriteM} & {LANES{reset}};
    assign w_tag[0] = dataadrM[31:2];
    assign w_tag[1] = dataadrM2[31:2];
    assign w_tag[2] = dataadrM3[31:2];
    assign w_tag[3] = dataadrM4[31:2];
    assign w_wd[0]  = writedata2M;
    assign w_wd[1]  = writedata2M2;
    assign w_wd[2]  = writedata2M3;
    assign w_wd[3]  = writedata2M4;
    assign w_unused_adr = ^{dataadrM[1:0], dataadrM2[1:0], dataadrM3[1:0], dataadrM4[1:0]};

    // Store count and compacted tail slot per asserted lane.
    always_comb begin
        w_n = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            w_slot[i] = r_tail + PW'(w_n);
            w_n       = w_n + 3'(w_we[i]);
        end
    end

    assign w_space   = CW'(DEPTH) - r_count;
    assign bufstallM = CW'(w_n) > w_space;
    assign w_acc     = !bufstallM && (w_n != 3'd0);
    assign w_drain   = (r_count != '0);
    assign w_enq     = w_acc && !w_byp;
    assign w_add     = w_enq ? CW'(w_n) : '0;

`ifdef DMEM_WBUF_BYPASS_EN
    logic [RAM_AW-1:0] w_byp_idx;
    logic [31:0]       w_byp_data;

    always_comb begin
        w_byp_idx  = '0;
        w_byp_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_we[i]) begin
                w_byp_idx  = w_tag[i][RAM_AW-1:0];
                w_byp_data = w_wd[i];
            end
        end
    end

    assign w_byp = w_acc && (r_count == '0) && (w_n == 3'd1);
`else
    assign w_byp = 1'b0;
`endif

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) r_head <= r_head + PW'(1);
            if (w_enq)   r_tail <= r_tail + PW'(w_n);
            r_count <= r_count + w_add - CW'(w_drain);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_enq && w_we[i]) begin
                r_q_tag[w_slot[i]]  <= w_tag[i];
                r_q_data[w_slot[i]] <= w_wd[i];
            end
        end
    end

    // Single RAM write port: head drain, or the bypass store when the queue is empty.
    always_ff @(posedge clk) begin
        if (reset && w_drain)
            r_ram[r_q_tag[r_head][RAM_AW-1:0]] <= r_q_data[r_head];
`ifdef DMEM_WBUF_BYPASS_EN
        else if (w_byp)
            r_ram[w_byp_idx] <= w_byp_data;
`endif
    end

    // Load lookup: RAM, overridden by youngest queue hit, overridden by youngest older-lane store.
    always_comb begin
        logic [PW-1:0] v_slot;
        v_slot = '0;
        for (int k = 0; k < LANES; k++) begin
            w_rd[k] = r_ram[w_tag[k][RAM_AW-1:0]];
            for (int a = 0; a < DEPTH; a++) begin
                v_slot = r_head + PW'(a);
                if ((CW'(a) < r_count) && (r_q_tag[v_slot] == w_tag[k]))
                    w_rd[k] = r_q_data[v_slot];
            end
            for (int j = 0; j < LANES; j++) begin
                if ((j < k) && w_we[j] && (w_tag[j] == w_tag[k]))
                    w_rd[k] = w_wd[j];
            end
        end
    end

    assign readdataM  = w_rd[0];
    assign readdataM2 = w_rd[1];
    assign readdataM3 = w_rd[2];
    assign readdataM4 = w_rd[3];
    assign wbuf_count = r_count;
    assign wbuf_empty = (r_count == '0);
endmodule
